pwm_capture: RTL
================

# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receiving end of the PWM generators in this design: it lets a PWM output be looped back and checked, and it lets external PWM commands be decoded. The input is asynchronous, so it is synchronised and edge-detected internally. Results are published once per completed period with a one-cycle valid strobe, and a missing edge is flagged by timeout.

## Interface
Parameters:
- CNT_W, 16, width of period/high-time counters and outputs
- SYNC_STAGES, 2, synchroniser flops on pwm_in (legal 2..4)
- TIMEOUT, 1000, cycles without a required edge before timeout; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1

Ports:
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- pwm_in  input  1  asynchronous PWM waveform
- period  output  CNT_W  cycles between the last two rising edges
- high_time  output  CNT_W  cycles pwm_in was high in that period
- valid  output  1  one-cycle strobe: period/high_time just updated
- timeout  output  1  level; set on timeout, cleared by next valid or reset
- stuck_level  output  1  synchronised pwm_in value captured at timeout

## Operation
- Definitions:
  - s is the last synchroniser stage; s_d is s delayed by one flop.
  - rise = s & ~s_d; fall = ~s & s_d.
- Counter cnt:
  - Loads 1 on every rise.
  - Otherwise increments, saturating at TIMEOUT.
- States:
  - IDLE (reset state): fall is ignored.
    - rise → HIGH; cnt ← 1; no valid.
  - HIGH:
    - fall → LOW; hi_lat ← cnt.
    - rise cannot occur in HIGH.
    - cnt == TIMEOUT → IDLE; timeout ← 1; stuck_level ← s.
  - LOW:
    - rise → HIGH; period ← cnt; high_time ← hi_lat; valid ← 1; timeout ← 0; cnt ← 1.
    - cnt == TIMEOUT → IDLE; timeout ← 1; stuck_level ← s.
- Measurement rules:
  - The first rise after reset or timeout only arms the block. The first valid follows the second rise.
  - Results are exact: high_time ≥ 1, period ≥ 2, high_time < period.
  - Because TIMEOUT ≤ 2^CNT_W−1, cnt never wraps.
- Timeout cases: 0 % duty times out in LOW; 100 % duty times out in HIGH.
  - timeout is asserted in the cycle after cnt reaches TIMEOUT.
  - It is not re-asserted while in IDLE.
  - period and high_time keep their last valid values.
- Reset:
  - Values: period = 0, high_time = 0, valid = 0, timeout = 0, stuck_level = 0, state IDLE, cnt = 0, synchroniser flops = 0.
  - Reset mid-period discards the partial measurement. No valid is produced until two rises after reset deasserts.

## Timing
- pwm_in first sampled high at edge E:
  - s is high after edge E+SYNC_STAGES−1.
  - rise is detected at edge E+SYNC_STAGES.
  - valid, period and high_time are registered at that edge.
  - Latency from pwm_in to valid is SYNC_STAGES+1 edges.
- valid is high for exactly one cycle per period. period and high_time are stable until the next valid.
- rise and TIMEOUT in the same cycle: rise wins (normal measurement, no timeout).
- A one-cycle high pulse on s measures high_time = 1.

## Structure
- Package pwm_pkg:
  - CNT_W default
  - state enum {IDLE, HIGH, LOW}
  - shared by pwm generators for counter width
- Sub-module pwm_sync: SYNC_STAGES flop chain plus s_d register. Outputs s, rise, fall.
- Top level holds the FSM, cnt, hi_lat and the output registers.

## Test plan
- Generator pattern, high 2 / low 18 cycles, repeated:
  - No valid after the first rise.
  - Then every 20 cycles: valid with period = 20, high_time = 2.
  - First valid lands SYNC_STAGES+1 edges after the second pwm_in rise.
- Duty change mid-stream, 5/20 → 15/40:
  - Exactly one transitional result, period = 20 (old period), high_time = 5.
  - Then steady period = 40, high_time = 15.
- pwm_in held high, TIMEOUT = 50:
  - timeout = 1 exactly 50 cycles after the detected rise; stuck_level = 1; period/high_time unchanged.
  - Then 3/10 pulses resume: timeout clears at the first valid, period = 10.
- pwm_in held low after running (same procedure as the held-high case):
  - timeout = 1, stuck_level = 0.
- reset asserted for 1 cycle mid-high-phase:
  - All outputs return to 0 on the next edge.
  - First valid after the second subsequent rise, with correct values.
- Minimum waveform, high 1 / low 1:
  - valid every 2 cycles with period = 2, high_time = 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture blocks: default counter
// width and the capture state encoding.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sync.sv
// Synchroniser for the asynchronous PWM input plus rise/fall edge detection
// on the synchronised level.
module pwm_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, publishing one
// result per completed period and flagging a missing edge by timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             s, rise, fall;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;

    pwm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_lat      <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;

            // cnt counts from the last rise and parks at TIMEOUT, so it never wraps
            if (rise)
                cnt <= ONE;
            else if (cnt < TO_VAL)
                cnt <= cnt + ONE;

            case (state)
                IDLE: begin
                    if (rise)
                        state <= HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        state  <= LOW;
                        hi_lat <= cnt;
                    end else if (cnt == TO_VAL) begin
                        state       <= IDLE;
                        timeout     <= 1'b1;
                        stuck_level <= s;
                    end
                end
                LOW: begin
                    // a rise on the timeout cycle still completes the period
                    if (rise) begin
                        state     <= HIGH;
                        period    <= cnt;
                        high_time <= hi_lat;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                    end else if (cnt == TO_VAL) begin
                        state       <= IDLE;
                        timeout     <= 1'b1;
                        stuck_level <= s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
